// File: rtl/poly_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_arith_pkg
//  Description : Shared types and constants for the polynomial arithmetic
//                stream: operation modes, FSM states, ternary coefficient
//                encoding, default sizes and the beat-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_arith_pkg;

    // Default geometry of one polynomial
    localparam int c_DEFAULT_COEF_W = 13;
    localparam int c_DEFAULT_N      = 701;
    localparam int c_DEFAULT_LANES  = 4;

    // Operation select, sampled with start
    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_TMAC = 2'b10,
        MODE_NEG  = 2'b11
    } mode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Ternary lane encoding; the reserved code behaves as zero
    localparam logic [1:0] c_TERN_ZERO = 2'b00;
    localparam logic [1:0] c_TERN_POS  = 2'b01;
    localparam logic [1:0] c_TERN_RSV  = 2'b10;
    localparam logic [1:0] c_TERN_NEG  = 2'b11;

    // Number of beats needed to carry n coefficients, lanes per beat
    function automatic int beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module      : poly_lane_alu
//  Description : One-lane combinational datapath. Every mode is mapped onto
//                y = p + (inv ? ~q : q) + inv, truncated to COEF_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_lane_alu
    import poly_arith_pkg::*;
#(
    parameter int COEF_W = c_DEFAULT_COEF_W
) (
    input  mode_e              i_mode,
    input  logic [COEF_W-1:0]  i_a,
    input  logic [COEF_W-1:0]  i_b,
    input  logic [1:0]         i_t,
    output logic [COEF_W-1:0]  o_y
);

    logic [COEF_W-1:0] w_p;
    logic [COEF_W-1:0] w_q;
    logic              w_inv;
    logic [COEF_W-1:0] w_q_eff;

    // Operand select and invert control per mode; the carry-in equals the
    // invert flag so that inverting yields a two's-complement negation
    always_comb begin
        w_p   = i_a;
        w_q   = i_b;
        w_inv = 1'b0;
        case (i_mode)
            MODE_ADD: begin
                w_p   = i_a;
                w_q   = i_b;
                w_inv = 1'b0;
            end
            MODE_SUB: begin
                w_p   = i_a;
                w_q   = i_b;
                w_inv = 1'b1;
            end
            MODE_TMAC: begin
                w_p = i_b;
                case (i_t)
                    c_TERN_POS: begin
                        w_q   = i_a;
                        w_inv = 1'b0;
                    end
                    c_TERN_NEG: begin
                        w_q   = i_a;
                        w_inv = 1'b1;
                    end
                    default: begin
                        w_q   = '0;
                        w_inv = 1'b0;
                    end
                endcase
            end
            MODE_NEG: begin
                w_p   = '0;
                w_q   = i_a;
                w_inv = 1'b1;
            end
            default: begin
                w_p   = i_a;
                w_q   = i_b;
                w_inv = 1'b0;
            end
        endcase
    end

    assign w_q_eff = w_inv ? ~w_q : w_q;
    assign o_y     = w_p + w_q_eff + COEF_W'(w_inv);

endmodule
`default_nettype wire

// File: rtl/poly_arith_stream.sv
`default_nettype none
// ============================================================================
//  Module      : poly_arith_stream
//  Description : Streams one polynomial of N coefficients, LANES per beat,
//                through a lane-parallel ADD/SUB/TMAC/NEG datapath with a
//                single registered output stage and valid/ready flow control.
//                Optional build macro POLY_ARITH_SUM_EN adds sum_out, the
//                running mod-2^COEF_W sum of all emitted coefficients.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_arith_stream
    import poly_arith_pkg::*;
#(
    parameter int COEF_W = c_DEFAULT_COEF_W,
    parameter int LANES  = c_DEFAULT_LANES,
    parameter int N      = c_DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*COEF_W-1:0]   a_in,
    input  logic [LANES*COEF_W-1:0]   b_in,
    input  logic [2*LANES-1:0]        t_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*COEF_W-1:0]   y_out,
    output logic                      last_out,
    output logic                      busy,
    output logic                      done
`ifdef POLY_ARITH_SUM_EN
    ,
    output logic [COEF_W-1:0]         sum_out
`endif
);

    localparam int c_BEATS      = beats(N, LANES);
    localparam int c_CNT_W      = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    // Lanes of the final beat that still carry real coefficients
    localparam int c_LAST_LANES = N - (c_BEATS - 1) * LANES;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    state_e                    r_state;
    state_e                    w_next;
    logic [c_CNT_W-1:0]        r_cnt;
    mode_e                     r_mode;
    logic                      r_valid;
    logic                      r_last;
    logic [LANES*COEF_W-1:0]   r_y;
    logic [LANES*COEF_W-1:0]   w_y;
    logic                      w_accept;
    logic                      w_take;
    logic                      w_last_beat;
    logic                      w_start_ok;

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign in_ready    = (r_state == ST_RUN) && (!r_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_take      = r_valid && out_ready;
    assign w_last_beat = (r_cnt == c_LAST_BEAT);

    assign out_valid = r_valid;
    assign last_out  = r_last;
    assign y_out     = r_y;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    // Lane datapath; padding lanes of the final beat are forced to zero
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [COEF_W-1:0] w_alu_y;

        poly_lane_alu #(
            .COEF_W (COEF_W)
        ) u_alu (
            .i_mode (r_mode),
            .i_a    (a_in[k*COEF_W +: COEF_W]),
            .i_b    (b_in[k*COEF_W +: COEF_W]),
            .i_t    (t_in[2*k +: 2]),
            .o_y    (w_alu_y)
        );

        if (k >= c_LAST_LANES) begin : g_pad
            assign w_y[k*COEF_W +: COEF_W] = w_last_beat ? '0 : w_alu_y;
        end else begin : g_live
            assign w_y[k*COEF_W +: COEF_W] = w_alu_y;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)                  w_next = ST_RUN;
            ST_RUN:   if (w_accept && w_last_beat) w_next = ST_DRAIN;
            ST_DRAIN: if (w_take)                 w_next = ST_DONE;
            ST_DONE:                              w_next = ST_IDLE;
            default:                              w_next = ST_IDLE;
        endcase
    end

    // Mode latch and beat counter; the counter stops at the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mode <= MODE_ADD;
        end else if (w_start_ok) begin
            r_cnt  <= '0;
            r_mode <= mode_e'(mode);
        end else if (w_accept && !w_last_beat) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Output register: load on accept, hold while stalled, drop once taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_y     <= w_y;
            r_valid <= 1'b1;
            r_last  <= w_last_beat;
        end else if (w_take) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

`ifdef POLY_ARITH_SUM_EN
    logic [COEF_W-1:0] r_sum;
    logic [COEF_W-1:0] w_beat_sum;

    // Sum of the lanes entering the output register; padding lanes are zero
    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_beat_sum = w_beat_sum + w_y[k*COEF_W +: COEF_W];
        end
    end

    // Running coefficient sum, cleared when an operation starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + w_beat_sum;
        end
    end

    assign sum_out = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_poly_arith_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_arith_stream
//  Description : Randomised scoreboard bench for poly_arith_stream. The driver
//                pushes expected beats computed from plain modular arithmetic;
//                an independent monitor pops and compares on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_arith_stream;

    localparam int W     = 13;
    localparam int L     = 4;
    localparam int NN    = 701;
    localparam int BEATS = (NN + L - 1) / L;
    localparam int M     = 1 << W;

    typedef struct packed {
        logic [L*W-1:0] y;
        logic           last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [L*W-1:0]   a_in;
    logic [L*W-1:0]   b_in;
    logic [2*L-1:0]   t_in;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   y_out;
    logic             last_out;
    logic             busy;
    logic             done;
`ifdef POLY_ARITH_SUM_EN
    logic [W-1:0]     sum_out;
`endif

    exp_t         q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           hold = 0;
    bit           rnd_ready = 0;
    int           cyc = 0;
    int           last_hs_cyc = 0;
    logic [W-1:0] exp_sum;

    poly_arith_stream #(
        .COEF_W (W),
        .LANES  (L),
        .N      (NN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .t_in      (t_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .last_out  (last_out),
        .busy      (busy),
        .done      (done)
`ifdef POLY_ARITH_SUM_EN
        ,
        .sum_out   (sum_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference: one coefficient from the arithmetic definition of each mode
    function automatic logic [W-1:0] ref_coef(input int m, input int i, input int a,
                                              input int b, input logic [1:0] t);
        int r;
        int tv;
        if (i >= NN) return '0;
        tv = (t == 2'b01) ? 1 : ((t == 2'b11) ? -1 : 0);
        case (m)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = b + tv * a;
            default: r = -a;
        endcase
        r = r % M;
        if (r < 0) r = r + M;
        return r[W-1:0];
    endfunction

    // Downstream ready generator, with forced stall windows
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                out_ready = 1'b0;
                hold      = hold - 1;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: compares on handshake and checks hold-stability under stall
    initial begin
        exp_t         e;
        logic         prev_stall;
        logic [L*W-1:0] prev_y;
        logic         prev_last;
        prev_stall = 1'b0;
        prev_y     = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_y", y_out, prev_y);
                    chk("stall_last", last_out, prev_last);
                end
                if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat actual=0x%0h expected=none", y_out);
                    end else begin
                        e = q.pop_front();
                        chk("beat_y", y_out, e.y);
                        chk("beat_last", last_out, e.last);
                        if (e.last) last_hs_cyc = cyc;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_y     = y_out;
                prev_last  = last_out;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_y"}, y_out, '0);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_last"}, last_out, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
`ifdef POLY_ARITH_SUM_EN
        chk({tag, "_sum"}, sum_out, '0);
`endif
    endtask

    // One operation. pat: 0 random, 1 a=i b=1, 2 a=0 b=1, 3 TMAC table, 4 a=1
    task automatic run_op(input int m, input int pat, input bit gaps, input bit noise,
                          input int bp_at, input int abort_at);
        int             beat;
        int             budget;
        bit             bp_armed;
        bit             aborted;
        bit             got;
        exp_t           e;
        logic [L*W-1:0] a_v;
        logic [L*W-1:0] b_v;
        logic [2*L-1:0] t_v;
        logic [7:0]     tcyc;
        tcyc     = 8'b10_00_11_01;
        bp_armed = (bp_at >= 0);
        aborted  = 1'b0;
        exp_sum  = '0;
        start    = 1'b1;
        mode     = m[1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_taken", busy, 1'b1);
        if (noise) mode = 2'($urandom_range(0, 3));
        beat   = 0;
        budget = 0;
        while (beat < BEATS) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int k = 0; k < L; k++) begin
                int i;
                int av;
                int bv;
                logic [1:0] tv;
                i  = beat * L + k;
                av = $urandom_range(0, M - 1);
                bv = $urandom_range(0, M - 1);
                tv = 2'($urandom_range(0, 3));
                case (pat)
                    1: begin av = i % M; bv = 1; tv = 2'b00; end
                    2: begin av = 0; bv = 1; end
                    3: begin av = 100; bv = 5; tv = tcyc[2*(i%4) +: 2]; end
                    4: begin av = 1; end
                    default: ;
                endcase
                a_v[k*W +: W] = av[W-1:0];
                b_v[k*W +: W] = bv[W-1:0];
                t_v[2*k +: 2] = tv;
            end
            a_in = a_v;
            b_in = b_v;
            t_in = t_v;
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                mode  = 2'($urandom_range(0, 3));
            end
            if (bp_armed && beat == bp_at) begin
                hold     = 10;
                bp_armed = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.y = '0;
                for (int k = 0; k < L; k++) begin
                    e.y[k*W +: W] = ref_coef(m, beat * L + k, int'(a_v[k*W +: W]),
                                             int'(b_v[k*W +: W]), t_v[2*k +: 2]);
                    exp_sum = exp_sum + e.y[k*W +: W];
                end
                e.last = (beat == BEATS - 1);
                q.push_back(e);
                beat++;
                if (abort_at > 0 && beat == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
            end
            budget++;
            if (budget > 20000) begin
                chk("input_timeout", beat, BEATS);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (aborted) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            chk("pre_abort_busy", busy, 1'b1);
            rst = 1'b1;
            #1;
            check_all_zero("abort");
            q.delete();
            hold = 0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        got      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("queue_empty_at_done", q.size(), 0);
            chk("done_latency", cyc - last_hs_cyc, 1);
            chk("busy_in_done", busy, 1'b1);
`ifdef POLY_ARITH_SUM_EN
            chk("sum_out", sum_out, exp_sum);
`endif
            start = 1'b1;
            mode  = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("done_pulse", done, 1'b0);
            chk("start_in_done_ignored", busy, 1'b0);
        end
    endtask

    // Global watchdog
    initial begin
        #800000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        t_in     = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Input beats offered while idle must be ignored
        in_valid = 1'b1;
        a_in     = '1;
        b_in     = '1;
        repeat (5) @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        in_valid = 1'b0;

        rnd_ready = 1'b0;
        run_op(0, 1, 1'b0, 1'b0, -1, 0);   // full ADD, a=i, b=1
        run_op(1, 2, 1'b1, 1'b0, -1, 0);   // SUB wrap to 8191
        rnd_ready = 1'b1;
        run_op(2, 3, 1'b1, 1'b0, -1, 0);   // TMAC 105/8097/5/5
        rnd_ready = 1'b0;
        run_op(0, 0, 1'b0, 1'b0, 20, 0);   // 10-cycle stall mid-run
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            run_op($urandom_range(0, 3), 0, 1'b1, 1'b1, -1, 0);
        end
        rnd_ready = 1'b0;
        run_op(0, 0, 1'b0, 1'b1, -1, 50);  // reset at beat 50
        run_op(2, 0, 1'b1, 1'b0, -1, 0);   // immediate restart after reset
        run_op(3, 4, 1'b0, 1'b0, -1, 0);   // NEG a=1

        repeat (5) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_arith_stream.md
POLY_ARITH_STREAM -- requirements
Module: poly_arith_stream

Interface
REQ-001 Parameter COEF_W, default 13: coefficient width; all arithmetic is mod 2^COEF_W.
REQ-002 Parameter LANES, default 4: coefficients processed per beat.
REQ-003 Parameter N, default 701: polynomial length in coefficients.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all registers update on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  begins one polynomial operation; honoured only in IDLE.
REQ-008 mode  input  2  operation select, sampled with start.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-011 a_in  input  LANES*COEF_W  operand A lanes; lane k is bits [k*COEF_W +: COEF_W].
REQ-012 b_in  input  LANES*COEF_W  operand B lanes.
REQ-013 t_in  input  2*LANES  ternary lanes: 00 is 0, 01 is +1, 11 is -1, 10 is reserved and treated as 0.
REQ-014 out_valid  output  1  result beat valid.
REQ-015 out_ready  input  1  downstream accepts the result beat.
REQ-016 y_out  output  LANES*COEF_W  result lanes.
REQ-017 last_out  output  1  high with the final result beat.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse at completion.

Function
REQ-020 Modes:
- 00 ADD: y = a + b.
- 01 SUB: y = a + ~b + 1.
- 10 TMAC: y = b + t*a.
- 11 NEG: y = ~a + 1.
REQ-021 Lane sums SHALL be truncated to COEF_W bits; carry-out is discarded.
REQ-022 Beat count is BEATS = ceil(N/LANES); a beat counter runs from 0 to BEATS-1 without wrap.
REQ-023 On the last beat, lanes with index >= N - (BEATS-1)*LANES SHALL output 0.
REQ-024 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-025 Transitions:
- IDLE to RUN on start: latch mode and clear the beat counter.
- RUN to DRAIN when the last beat is accepted.
- DRAIN to DONE when the last result is taken (out_valid and out_ready both high).
- DONE to IDLE unconditionally after one cycle.
REQ-026 in_ready = (state == RUN) and (!out_valid or out_ready).
REQ-027 Latency: an accepted beat appears on y_out on the next cycle through a single output register.
REQ-028 y_out, out_valid and last_out SHALL hold stable while out_valid is high and out_ready is low.
REQ-029 start outside IDLE, and mode changes after start, SHALL be ignored.
REQ-030 in_valid outside RUN SHALL be ignored; no beat is accepted.
REQ-031 done SHALL be high only in DONE; a start asserted in DONE is ignored.

Reset
REQ-032 Asserting rst SHALL immediately force the following, including mid-operation; any partial result is discarded:
- state = IDLE.
- beat counter = 0.
- latched mode = 00.
- y_out = 0; out_valid, last_out, in_ready, busy, done = 0.
- sum_out = 0 (when present).
REQ-033 After rst deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-034 With macro POLY_ARITH_SUM_EN defined:
- Add output sum_out, COEF_W bits.
- sum_out holds the mod-2^COEF_W sum of all emitted non-padding result lanes.
- sum_out is cleared on start and is valid while done is high.
REQ-035 Without POLY_ARITH_SUM_EN: no sum_out port and no sum logic.

Structure
REQ-036 Shared package poly_arith_pkg SHALL contain:
- the mode enum (ADD, SUB, TMAC, NEG);
- the FSM state enum;
- the ternary encoding constants;
- default COEF_W = 13 and N = 701;
- a beats(N, LANES) function.
REQ-037 Sub-module poly_lane_alu SHALL be combinational, one lane wide: operand select, conditional invert, carry-in, COEF_W-bit adder; instantiated LANES times.

Verification
REQ-038 Bench SHALL cover the following scenarios (default parameters unless stated):
- Full ADD run: ADD, N=701, LANES=4, a=i, b=1 -> 176 beats, y[i]=i+1; last beat lanes 1..3 = 0; last_out on beat 175; done one cycle later.
- SUB wrap: SUB, a=0, b=1 -> every coefficient = 8191.
- TMAC: TMAC, a=100, b=5, t cycling +1/-1/0/reserved -> 105, 8097, 5, 5.
- Backpressure: out_ready low for 10 cycles mid-run -> y_out stable; in_ready low; no beat lost or duplicated.
- Reset mid-run: rst asserted at beat 50 -> all outputs 0 immediately; a new start completes correctly.
- Sum feature: with POLY_ARITH_SUM_EN, NEG, a=1 -> sum_out = (8191*701) mod 8192 = 7491 while done is high.
